// File: rtl/seg7_pkg.sv
// Shared types and constants for the 4-digit multiplexed 7-segment display path.
package seg7_pkg;

  localparam int unsigned NUM_DIGITS = 4;
  localparam int unsigned DIGIT_W    = 2;
  localparam int unsigned NIBBLE_W   = 4;
  localparam int unsigned DATA_W     = NUM_DIGITS * NIBBLE_W;

  typedef logic [DIGIT_W-1:0] digit_idx_t;

  localparam logic                  DOT_OFF   = 1'b1;
  localparam logic [NUM_DIGITS-1:0] ALL_BLANK = 4'b1111;

  // One complete display image: nibbles, dot enables and blank mask.
  typedef struct packed {
    logic [DATA_W-1:0]     data;
    logic [NUM_DIGITS-1:0] dots;
    logic [NUM_DIGITS-1:0] blank;
  } disp_word_t;

  localparam disp_word_t DISP_RESET = '{data: '0, dots: '0, blank: ALL_BLANK};

  typedef enum logic {
    ST_GUARD = 1'b0,
    ST_SHOW  = 1'b1
  } slot_state_t;

endpackage

// File: rtl/seg7_prescaler.sv
// Slot prescaler: counts 0..REFRESH_DIV-1 and flags the last cycle of each slot.
module seg7_prescaler #(
  parameter int unsigned REFRESH_DIV = 100000,
  parameter int unsigned CNT_W       = $clog2(REFRESH_DIV)
) (
  input  logic             clk,
  input  logic             rst_n,
  output logic [CNT_W-1:0] count,
  output logic             slot_end
);

  logic [CNT_W-1:0] cnt_nxt;

  always_comb begin
    cnt_nxt = (count == CNT_W'(REFRESH_DIV - 1)) ? '0 : count + CNT_W'(1);
  end

  // slot_end is registered so it is high exactly while count sits at its top value.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count    <= '0;
      slot_end <= 1'b0;
    end else begin
      count    <= cnt_nxt;
      slot_end <= (cnt_nxt == CNT_W'(REFRESH_DIV - 1));
    end
  end

endmodule

// File: rtl/seg7_scan_driver.sv
// Multiplexed 4-digit scan driver with guard blanking and frame-aligned, double-buffered loads.
module seg7_scan_driver
  import seg7_pkg::*;
#(
  parameter int unsigned REFRESH_DIV  = 100000,
  parameter int unsigned GUARD_CYCLES = 1000
) (
  input  logic                  CLK,
  input  logic                  RESET_N,
  input  logic [DATA_W-1:0]     DATA_IN,
  input  logic [NUM_DIGITS-1:0] DOTS_IN,
  input  logic [NUM_DIGITS-1:0] BLANK_IN,
  input  logic                  LOAD_IN,
  output logic [DIGIT_W-1:0]    SEG_SELECT_OUT,
  output logic [NIBBLE_W-1:0]   BIN_OUT,
  output logic                  DOT_OUT,
  output logic                  DIGIT_EN_OUT,
  output logic                  LOAD_ACK_OUT
);

  localparam int unsigned CNT_W = $clog2(REFRESH_DIV);

  logic [CNT_W-1:0] count;
  logic             slot_end;
  logic             frame_end;

  slot_state_t state_q, state_d;
  digit_idx_t  sel_q, sel_d;
  disp_word_t  active_q, active_d;
  disp_word_t  pending_q, pending_d;
  logic        pend_valid_q, pend_valid_d;
  logic [NIBBLE_W-1:0] bin_d;
  logic        dot_d, en_d, ack_d;

  seg7_prescaler #(
    .REFRESH_DIV (REFRESH_DIV),
    .CNT_W       (CNT_W)
  ) u_prescaler (
    .clk      (CLK),
    .rst_n    (RESET_N),
    .count    (count),
    .slot_end (slot_end)
  );

  // Next-state, buffer transfer and registered-output decode.
  always_comb begin
    state_d      = state_q;
    sel_d        = sel_q;
    active_d     = active_q;
    pending_d    = pending_q;
    pend_valid_d = pend_valid_q;
    ack_d        = 1'b0;
    frame_end    = slot_end && (sel_q == DIGIT_W'(NUM_DIGITS - 1));

    case (state_q)
      ST_GUARD: if (count == CNT_W'(GUARD_CYCLES - 1)) state_d = ST_SHOW;
      ST_SHOW:  if (slot_end) state_d = ST_GUARD;
      default:  state_d = ST_GUARD;
    endcase

    if (slot_end) sel_d = sel_q + DIGIT_W'(1);

    if (frame_end && pend_valid_q) begin
      active_d     = pending_q;
      pend_valid_d = 1'b0;
      ack_d        = 1'b1;
    end

    // A load on the boundary cycle lands in pending after the old contents moved out.
    if (LOAD_IN) begin
      pending_d    = '{data: DATA_IN, dots: DOTS_IN, blank: BLANK_IN};
      pend_valid_d = 1'b1;
    end

    bin_d = active_d.data[{sel_d, 2'b00} +: NIBBLE_W];
    dot_d = ~active_d.dots[sel_d];
    en_d  = (state_d == ST_SHOW) && !active_d.blank[sel_d];
  end

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      state_q      <= ST_GUARD;
      sel_q        <= '0;
      active_q     <= DISP_RESET;
      pending_q    <= '0;
      pend_valid_q <= 1'b0;
      BIN_OUT      <= '0;
      DOT_OUT      <= DOT_OFF;
      DIGIT_EN_OUT <= 1'b0;
      LOAD_ACK_OUT <= 1'b0;
    end else begin
      state_q      <= state_d;
      sel_q        <= sel_d;
      active_q     <= active_d;
      pending_q    <= pending_d;
      pend_valid_q <= pend_valid_d;
      BIN_OUT      <= bin_d;
      DOT_OUT      <= dot_d;
      DIGIT_EN_OUT <= en_d;
      LOAD_ACK_OUT <= ack_d;
    end
  end

  assign SEG_SELECT_OUT = sel_q;

endmodule

// File: tb/tb_seg7_scan_driver.sv
// Scoreboard bench for seg7_scan_driver with REFRESH_DIV=8, GUARD_CYCLES=2.
module tb_seg7_scan_driver;
  import seg7_pkg::*;

  localparam int SLOT  = 8;
  localparam int GUARD = 2;
  localparam int FRAME = 4 * SLOT;

  logic        CLK;
  logic        RESET_N;
  logic [15:0] DATA_IN;
  logic [3:0]  DOTS_IN;
  logic [3:0]  BLANK_IN;
  logic        LOAD_IN;
  logic [1:0]  SEG_SELECT_OUT;
  logic [3:0]  BIN_OUT;
  logic        DOT_OUT;
  logic        DIGIT_EN_OUT;
  logic        LOAD_ACK_OUT;

  seg7_scan_driver #(
    .REFRESH_DIV  (SLOT),
    .GUARD_CYCLES (GUARD)
  ) dut (
    .CLK            (CLK),
    .RESET_N        (RESET_N),
    .DATA_IN        (DATA_IN),
    .DOTS_IN        (DOTS_IN),
    .BLANK_IN       (BLANK_IN),
    .LOAD_IN        (LOAD_IN),
    .SEG_SELECT_OUT (SEG_SELECT_OUT),
    .BIN_OUT        (BIN_OUT),
    .DOT_OUT        (DOT_OUT),
    .DIGIT_EN_OUT   (DIGIT_EN_OUT),
    .LOAD_ACK_OUT   (LOAD_ACK_OUT)
  );

  typedef struct {
    disp_word_t word;
    int         ack_k;
  } sb_entry_t;

  sb_entry_t  sb[$];
  disp_word_t shown;
  int         k;
  int         n_checks;
  int         n_errors;
  logic       mon_en;
  logic       popped;
  logic [1:0] sel_e;

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // Cycles since reset release; equals the prescaler count modulo SLOT.
  always @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) k <= 0;
    else          k <= k + 1;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at k=%0d", tag, got, exp, k);
    end
  endtask

  task automatic goto(input int target);
    int n;
    n = 0;
    while (k < target && n < 2000) begin
      @(negedge CLK);
      n++;
    end
    check("goto_timeout", 32'(k), 32'(target));
  endtask

  // Drive one load strobe from a negedge; loads landing before the same boundary collapse.
  task automatic do_load(input logic [15:0] d, input logic [3:0] dt, input logic [3:0] bl);
    sb_entry_t e;
    e.word  = '{data: d, dots: dt, blank: bl};
    e.ack_k = FRAME * ((k + 1) / FRAME + 1);
    if (sb.size() > 0 && sb[$].ack_k == e.ack_k) sb[$] = e;
    else sb.push_back(e);
    DATA_IN  = d;
    DOTS_IN  = dt;
    BLANK_IN = bl;
    LOAD_IN  = 1'b1;
    @(negedge CLK);
    LOAD_IN  = 1'b0;
  endtask

  task automatic check_reset_outputs();
    check("rst_sel", 32'(SEG_SELECT_OUT), 32'(0));
    check("rst_bin", 32'(BIN_OUT), 32'(0));
    check("rst_dot", 32'(DOT_OUT), 32'(1));
    check("rst_en",  32'(DIGIT_EN_OUT), 32'(0));
    check("rst_ack", 32'(LOAD_ACK_OUT), 32'(0));
  endtask

  // Per-cycle display monitor against the expected image and slot timing.
  always @(negedge CLK) begin
    if (mon_en && RESET_N) begin
      popped = 1'b0;
      if (sb.size() > 0 && sb[0].ack_k == k) begin
        shown = sb[0].word;
        void'(sb.pop_front());
        popped = 1'b1;
      end
      sel_e = 2'((k / SLOT) % 4);
      check("sel", 32'(SEG_SELECT_OUT), 32'(sel_e));
      check("bin", 32'(BIN_OUT), 32'(4'(shown.data >> (4 * sel_e))));
      check("dot", 32'(DOT_OUT), 32'(!shown.dots[sel_e]));
      check("en",  32'(DIGIT_EN_OUT), 32'((k % SLOT >= GUARD) && !shown.blank[sel_e]));
      check("ack", 32'(LOAD_ACK_OUT), 32'(popped));
    end
  end

  initial begin
    n_checks = 0;
    n_errors = 0;
    mon_en   = 1'b0;
    shown    = DISP_RESET;
    DATA_IN  = '0;
    DOTS_IN  = '0;
    BLANK_IN = '0;
    LOAD_IN  = 1'b0;
    RESET_N  = 1'b1;
    #1 RESET_N = 1'b0;
    repeat (3) @(negedge CLK);
    check_reset_outputs();
    #2 RESET_N = 1'b1;
    mon_en = 1'b1;

    goto(40);
    do_load(16'h1234, 4'b0010, 4'b0000);

    goto(70);
    do_load(16'hAAAA, 4'b0000, 4'b0000);
    goto(80);
    do_load(16'h5555, 4'b0000, 4'b0000);

    goto(100);
    do_load(16'h0F0F, 4'b0000, 4'b0000);
    goto(FRAME * 4 - 1);
    do_load(16'hBEEF, 4'b0101, 4'b0000);

    goto(170);
    do_load(16'h4321, 4'b0000, 4'b1000);

    goto(230);
    do_load(16'h9999, 4'b1111, 4'b0000);
    goto(240);
    #2 RESET_N = 1'b0;
    sb.delete();
    shown = DISP_RESET;
    #1 check_reset_outputs();
    repeat (2) @(negedge CLK);
    #2 RESET_N = 1'b1;

    goto(3 * FRAME);
    check("sb_empty", 32'(sb.size()), 32'(0));
    mon_en = 1'b0;
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/seg7_scan_driver.md
SEG7_SCAN_DRIVER -- requirements
Module: seg7_scan_driver

Interface
REQ-001 SHALL have parameter REFRESH_DIV, default 100000: CLK cycles per digit slot (legal range 4..2^20).
REQ-002 SHALL have parameter GUARD_CYCLES, default 1000: blanked cycles at the start of each slot for anti-ghosting (legal range 1..REFRESH_DIV-2).
REQ-003 SHALL use one clock; reset is asynchronous and active-low.
REQ-004 SHALL have port CLK, input, 1 bit: the single clock, rising edge.
REQ-005 SHALL have port RESET_N, input, 1 bit: asynchronous active-low reset.
REQ-006 SHALL have port DATA_IN, input, 16 bits: four nibbles; [3:0] is digit 0, [15:12] is digit 3.
REQ-007 SHALL have port DOTS_IN, input, 4 bits: bit i high lights the dot of digit i.
REQ-008 SHALL have port BLANK_IN, input, 4 bits: bit i high blanks digit i.
REQ-009 SHALL have port LOAD_IN, input, 1 bit: single-cycle strobe that captures DATA_IN, DOTS_IN and BLANK_IN.
REQ-010 SHALL have port SEG_SELECT_OUT, output, 2 bits: current digit index, for the segment decoder's select input.
REQ-011 SHALL have port BIN_OUT, output, 4 bits: nibble of the current digit, for the decoder's binary input.
REQ-012 SHALL have port DOT_OUT, output, 1 bit: active-low dot; 0 means lit.
REQ-013 SHALL have port DIGIT_EN_OUT, output, 1 bit: high when the selected anode may be driven.
REQ-014 SHALL have port LOAD_ACK_OUT, output, 1 bit: one-cycle pulse when a captured load becomes visible on the display.

Function
REQ-015 SHALL hold a prescaler count 0..REFRESH_DIV-1; the slot ends when the count reaches REFRESH_DIV-1, then the count returns to 0.
REQ-016 SHALL advance SEG_SELECT_OUT 0->1->2->3->0 at each slot end.
REQ-017 SHALL define the frame boundary as the slot end with SEG_SELECT_OUT=3, i.e. the wrap from 3 to 0.
REQ-018 SHALL run a per-slot state machine:
- GUARD: DIGIT_EN_OUT=0 while count < GUARD_CYCLES.
- SHOW: after GUARD, DIGIT_EN_OUT = NOT active_blank[sel].
- SHOW returns to GUARD at every slot end.
REQ-019 SHALL drive BIN_OUT = active_data[4*sel+:4] and DOT_OUT = NOT active_dots[sel]; both are registered and change in the same cycle as SEG_SELECT_OUT.
REQ-020 SHALL, on LOAD_IN=1, write all three inputs into a pending register and set pending_valid.
REQ-021 SHALL apply last-wins when several loads arrive within one frame; all of them produce one ack.
REQ-022 SHALL, at a frame boundary with pending_valid=1, copy pending into active, clear pending_valid, and pulse LOAD_ACK_OUT in the next cycle.
REQ-023 SHALL never change the active register at any point other than a frame boundary, so no frame mixes old and new data.
REQ-024 SHALL, when LOAD_IN coincides with a frame boundary, transfer the prior pending contents (if valid) and keep the new load pending with pending_valid=1 for the next frame.
REQ-025 SHALL, when LOAD_IN coincides with a boundary and nothing was pending, take no transfer; the new load shows at the following boundary.
REQ-026 SHALL have a latency from a LOAD_IN to visible data of at most 4*REFRESH_DIV+1 cycles.

Reset
REQ-027 SHALL, while RESET_N=0, immediately force:
- SEG_SELECT_OUT=0, BIN_OUT=0, DOT_OUT=1, DIGIT_EN_OUT=0, LOAD_ACK_OUT=0;
- prescaler=0, state GUARD;
- active_data=0, active_dots=0, active_blank=4'b1111;
- pending cleared, pending_valid=0.
REQ-028 SHALL discard any pending load when reset is asserted mid-frame; no ack follows release.
REQ-029 SHALL start counting on the first CLK edge after RESET_N rises, with SEG_SELECT_OUT=0.

Structure
REQ-030 SHALL place the following in shared package seg7_pkg for reuse by the decoder-side top level:
- NUM_DIGITS=4;
- the 2-bit digit index type;
- DOT_OFF=1'b1;
- the ALL_BLANK=4'b1111 constant.
REQ-031 SHALL implement the prescaler as sub-module seg7_prescaler, which outputs a one-cycle slot_end pulse and the current count.

Verification (REFRESH_DIV=8, GUARD_CYCLES=2)
REQ-032 SHALL cover reset: release reset -> SEG_SELECT_OUT sequences 0,1,2,3,0 every 8 cycles, DIGIT_EN_OUT=0 throughout (all blank), DOT_OUT=1.
REQ-033 SHALL cover a basic load: LOAD_IN with DATA_IN=16'h1234, DOTS_IN=4'b0010, BLANK_IN=0 -> at the next boundary:
- LOAD_ACK_OUT pulses once;
- BIN_OUT reads 4,3,2,1 for digits 0..3;
- DOT_OUT=0 only on digit 1;
- DIGIT_EN_OUT is low for 2 cycles, then high for 6 cycles, in each slot.
REQ-034 SHALL cover last-wins: loads 16'hAAAA then 16'h5555 within one frame -> a single ack, and display shows 5555 only.
REQ-035 SHALL cover a load coincident with the boundary: 16'h0F0F pending, then LOAD_IN 16'hBEEF on the boundary cycle -> 0F0F is shown with an ack, and BEEF is shown with a second ack one frame later.
REQ-036 SHALL cover blanking: BLANK_IN=4'b1000 -> DIGIT_EN_OUT stays 0 for the entire digit-3 slot.
REQ-037 SHALL cover mid-frame reset: load 16'h9999, assert RESET_N=0 before the boundary -> after release, no ack occurs and all digits stay blank.
